// File: rtl/dut_arb_pkg.sv
// Shared types for the dut port arbiter: FSM states, default dut widths,
// the transaction record and the round-robin wrap helper.
package dut_arb_pkg;

  localparam int DEF_ADDR_W = 3;
  localparam int DEF_DATA_W = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic                  write;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] wdata;
  } arb_txn_t;

  function automatic int wrap_inc(input int v, input int n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping.
// Zero latency; no state, the caller owns the pointer.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  always_comb begin
    int j;
    j     = 0;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(ptr_i) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!any_o && req_i[j]) begin
        any_o    = 1'b1;
        gnt_o[j] = 1'b1;
        idx_o    = IDX_W'(j);
      end
    end
  end

endmodule

// File: rtl/dut_port_arbiter.sv
// Round-robin sharing of the dut write/read ports; one transaction per 3 cycles
// minimum (grant, issue, respond). A low dut rdy stalls ISSUE up to TIMEOUT cycles.
module dut_port_arbiter
  import dut_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         write_address,
  output logic [DATA_W-1:0]         write_data,
  output logic                      write_en,
  input  logic                      write_rdy,
  output logic [ADDR_W-1:0]         read_address,
  output logic                      read_en,
  input  logic [DATA_W-1:0]         read_data,
  input  logic                      read_rdy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT);

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } txn_t;

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   gnt_idx_q;
  txn_t               txn_q;
  txn_t               pick_txn;
  logic [DATA_W-1:0]  rdata_q;
  logic               err_q;
  logic [CNT_W-1:0]   wait_q;

  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic               in_issue;
  logic               sel_rdy;
  logic               timeout_hit;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .any_o (arb_any)
  );

  always_comb begin
    pick_txn = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == IDX_W'(i)) begin
        pick_txn.write = req_write[i];
        pick_txn.addr  = req_addr[i*ADDR_W +: ADDR_W];
        pick_txn.wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  assign in_issue    = (state_q == ST_ISSUE);
  assign sel_rdy     = txn_q.write ? write_rdy : read_rdy;
  assign timeout_hit = in_issue && !sel_rdy && (wait_q == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (arb_any) state_d = ST_ISSUE;
      ST_ISSUE: if (sel_rdy || timeout_hit) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      txn_q     <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      wait_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_idx_q <= arb_idx;
            txn_q     <= pick_txn;
          end
          rdata_q <= '0;
          err_q   <= 1'b0;
          wait_q  <= '0;
        end
        ST_ISSUE: begin
          if (sel_rdy) begin
            wait_q <= '0;
            if (!txn_q.write) rdata_q <= read_data;
          end else if (timeout_hit) begin
            wait_q <= '0;
            err_q  <= 1'b1;
          end else begin
            wait_q <= wait_q + CNT_W'(1);
          end
        end
        ST_RESP: ptr_q <= IDX_W'(wrap_inc(int'(gnt_idx_q), NUM_REQ));
        default: ;
      endcase
    end
  end

  // en follows rdy combinationally so it is never raised against a low rdy
  always_comb begin
    req_ready     = (state_q == ST_IDLE && !RST) ? arb_gnt : '0;
    write_en      = in_issue && txn_q.write && write_rdy;
    read_en       = in_issue && !txn_q.write && read_rdy;
    write_address = (in_issue && txn_q.write) ? txn_q.addr : '0;
    write_data    = (in_issue && txn_q.write) ? txn_q.wdata : '0;
    read_address  = (in_issue && !txn_q.write) ? txn_q.addr : '0;
    rsp_data      = (state_q == ST_RESP) ? rdata_q : '0;
    rsp_err       = (state_q == ST_RESP) && err_q;
    rsp_valid     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = (state_q == ST_RESP) && (gnt_idx_q == IDX_W'(i));
    end
  end

endmodule

// File: tb/tb_dut_port_arbiter.sv
// Directed bench for dut_port_arbiter: single write/read, round-robin order,
// rdy stall, timeout abort and reset during a stalled issue.
module tb_dut_port_arbiter;
  import dut_arb_pkg::*;

  localparam int N  = 4;
  localparam int AW = 3;
  localparam int DW = 1;

  logic            CLK = 1'b0;
  logic            RST;
  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [DW-1:0]   rsp_data, write_data, read_data;
  logic            rsp_err, write_en, write_rdy, read_en, read_rdy;
  logic [AW-1:0]   write_address, read_address;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 CLK = ~CLK;

  dut_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .CLK(CLK), .RST(RST),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .write_address(write_address), .write_data(write_data),
    .write_en(write_en), .write_rdy(write_rdy),
    .read_address(read_address), .read_en(read_en),
    .read_data(read_data), .read_rdy(read_rdy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One full grant/issue/respond transaction with both rdy high.
  task automatic run_xact(input int r, input arb_txn_t t, input logic [DW-1:0] rdat);
    logic [N-1:0] oh;
    oh = 4'b0001 << r;
    req_valid[r]          = 1'b1;
    req_write[r]          = t.write;
    req_addr[r*AW +: AW]  = t.addr;
    req_wdata[r*DW +: DW] = t.wdata;
    #1 check("x_grant", 32'(req_ready), 32'(oh));
    tick();
    req_valid[r] = 1'b0;
    read_data    = rdat;
    #1 check("x_wen", 32'(write_en), 32'(t.write));
    check("x_ren", 32'(read_en), 32'(!t.write));
    check("x_addr", 32'(t.write ? write_address : read_address), 32'(t.addr));
    if (t.write) check("x_wdata", 32'(write_data), 32'(t.wdata));
    tick();
    #1 check("x_rsp", 32'(rsp_valid), 32'(oh));
    check("x_rdata", 32'(rsp_data), t.write ? 32'd0 : 32'(rdat));
    check("x_err", 32'(rsp_err), 32'd0);
    check("x_en_off", 32'({write_en, read_en}), 32'd0);
    tick();
    read_data = '0;
  endtask

  initial begin
    RST = 1'b1; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    write_rdy = 1'b1; read_rdy = 1'b1; read_data = '0;
    tick(); tick();
    #1 check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp", 32'(rsp_valid), 32'd0);
    check("rst_en", 32'({write_en, read_en}), 32'd0);
    check("rst_addr", 32'({write_address, read_address, write_data}), 32'd0);
    check("rst_data", 32'({rsp_data, rsp_err}), 32'd0);
    RST = 1'b0;
    tick();

    // single write then read-back
    run_xact(0, '{1'b1, 3'd5, 1'b1}, 1'b0);
    run_xact(2, '{1'b0, 3'd5, 1'b0}, 1'b1);

    // reset with everyone requesting, then round-robin 0,1,2,3,0
    RST = 1'b1; req_valid = 4'hF; req_write = 4'hF;
    req_addr = {3'd3, 3'd2, 3'd1, 3'd0}; req_wdata = 4'b1010;
    #1 check("rr_rst_gate", 32'(req_ready), 32'd0);
    tick();
    RST = 1'b0;
    #1;
    for (int k = 0; k < 5; k++) begin
      check("rr_grant", 32'(req_ready), 32'(4'b0001 << (k % 4)));
      tick();
      #1 check("rr_wen", 32'(write_en), 32'd1);
      check("rr_waddr", 32'(write_address), 32'(k % 4));
      check("rr_ready_issue", 32'(req_ready), 32'd0);
      tick();
      #1 check("rr_rsp", 32'(rsp_valid), 32'(4'b0001 << (k % 4)));
      check("rr_ready_resp", 32'(req_ready), 32'd0);
      tick();
      #1;
    end
    req_valid = '0;

    // write stall: rdy low for 5 cycles
    write_rdy = 1'b0;
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[5:3] = 3'd3; req_wdata[1] = 1'b1;
    #1 check("st_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid[1] = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1 check("st_wen_low", 32'(write_en), 32'd0);
      check("st_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    write_rdy = 1'b1;
    #1 check("st_wen", 32'(write_en), 32'd1);
    check("st_waddr", 32'(write_address), 32'd3);
    tick();
    #1 check("st_rsp", 32'(rsp_valid), 32'b0010);
    check("st_err", 32'(rsp_err), 32'd0);
    check("st_wen_once", 32'(write_en), 32'd0);
    tick();

    // read timeout with requester 3 waiting behind
    read_rdy = 1'b0; read_data = 1'b1;
    req_valid = 4'b1100; req_write = 4'b1000; req_addr[8:6] = 3'd6;
    #1 check("to_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    for (int i = 0; i < 16; i++) begin
      #1 check("to_ren_low", 32'(read_en), 32'd0);
      check("to_no_rsp", 32'(rsp_valid), 32'd0);
      tick();
    end
    #1 check("to_rsp", 32'(rsp_valid), 32'b0100);
    check("to_err", 32'(rsp_err), 32'd1);
    check("to_rdata", 32'(rsp_data), 32'd0);
    tick();
    #1 check("to_next", 32'(req_ready), 32'b1000);
    tick();
    req_valid[3] = 1'b0; read_rdy = 1'b1; read_data = '0;
    #1 check("to_next_wen", 32'(write_en), 32'd1);
    tick();
    #1 check("to_next_rsp", 32'(rsp_valid), 32'b1000);
    tick();

    // reset during a stalled issue: dropped, pointer back to 0
    run_xact(0, '{1'b1, 3'd1, 1'b0}, 1'b0);
    write_rdy = 1'b0;
    req_valid[2] = 1'b1; req_write[2] = 1'b1; req_addr[8:6] = 3'd7;
    #1 check("rs_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid[2] = 1'b0;
    #1 check("rs_stall", 32'(write_en), 32'd0);
    tick();
    RST = 1'b1;
    tick();
    RST = 1'b0; write_rdy = 1'b1;
    #1 check("rs_wen", 32'(write_en), 32'd0);
    check("rs_waddr", 32'(write_address), 32'd0);
    check("rs_rsp", 32'(rsp_valid), 32'd0);
    check("rs_ready", 32'(req_ready), 32'd0);
    tick();
    #1 check("rs_dropped", 32'(rsp_valid), 32'd0);
    req_valid = 4'b0110; req_write = 4'b0110;
    #1 check("rs_ptr0_grant", 32'(req_ready), 32'b0010);
    req_valid = 4'b0011; req_write = 4'b0011;
    #1 check("rs_req0_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    tick(); tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/dut_port_arbiter.md
Name: dut_port_arbiter

Overview:
- Shares the dut's single write port and single read port among NUM_REQ requesters (testbench drivers or upstream agents).
- Arbitrates round-robin and sequences one transaction at a time onto the dut's en/rdy handshake.
- Returns read data or write acknowledgements to the granted requester.
- Sits between requesters and the dut, in place of direct drive of write_*/read_*.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 3, dut address width.
- DATA_W, 1, dut data width.
- TIMEOUT, 16, max consecutive cycles to wait on a low dut rdy before aborting (>=2).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request pending.
- req_write  input  NUM_REQ  1=write, 0=read, per requester.
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  input  NUM_REQ*DATA_W  packed write data.
- req_ready  output  NUM_REQ  one-hot accept pulse; request i taken this cycle.
- rsp_valid  output  NUM_REQ  one-hot completion pulse.
- rsp_data  output  DATA_W  read data for the rsp_valid requester; 0 for writes and errors.
- rsp_err  output  1  qualifies rsp_valid; 1 = aborted on timeout.
- write_address  output  ADDR_W  to dut.
- write_data  output  DATA_W  to dut.
- write_en  output  1  to dut.
- write_rdy  input  1  from dut.
- read_address  output  ADDR_W  to dut.
- read_en  output  1  to dut.
- read_data  input  DATA_W  from dut; valid in the cycle read_en && read_rdy.
- read_rdy  input  1  from dut.

Behaviour:
- Reset values: req_ready=0, rsp_valid=0, rsp_data=0, rsp_err=0, write_en=0, read_en=0, addresses/write_data=0, state=IDLE, rr pointer=0 (requester 0 highest priority), wait counter=0.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - If any req_valid, grant the first set bit searching from ptr upward with wrap.
  - Pulse req_ready[g] for 1 cycle and latch write/addr/wdata and g.
  - Go to ISSUE.
  - If no req_valid, stay in IDLE.
- ISSUE:
  - Drive the latched address/data onto the selected port; the unused port's en stays 0.
  - en = selected rdy (combinational), so en is never high while rdy is low.
  - In the cycle en && rdy: for a read, capture read_data into the rsp register; go to RESP; clear the wait counter.
  - If rdy is low, increment the wait counter. On reaching TIMEOUT-1 with rdy still low: go to RESP with the error flag set; no en is ever asserted.
- RESP:
  - Pulse rsp_valid[g] for 1 cycle.
  - rsp_data = captured read data (read), or 0 (write or error). rsp_err = error flag.
  - Set ptr = (g+1) mod NUM_REQ. Go to IDLE.
- Latency: accept to dut en >= 1 cycle; dut en to rsp_valid = 1 cycle. Back-to-back throughput is 1 transaction per 3 cycles.
- Requester rule: hold req_valid and payload stable until req_ready. req_valid dropped before grant is legal; the request is simply not seen.
- Requests arriving in ISSUE/RESP wait; req_ready is never asserted outside IDLE.
- Simultaneous requests: exactly one grant; the others are served in rotation, with no starvation (worst-case wait NUM_REQ-1 transactions).
- The granted requester may re-request immediately after rsp_valid; it has the lowest priority next round.
- RST asserted in any state:
  - Next cycle is IDLE with all outputs at reset values.
  - An in-flight transaction is dropped without rsp_valid.
  - A dut en already issued in that cycle is not retracted.
- Invariants: never write_en && read_en together; at most one rsp_valid bit and one req_ready bit set.

Decomposition:
- Package dut_arb_pkg:
  - State enum (IDLE/ISSUE/RESP).
  - Default ADDR_W/DATA_W constants.
  - A transaction struct {write, addr, wdata}.
- Sub-module rr_arbiter (NUM_REQ): req vector + ptr in, one-hot grant + index out; purely combinational.
- dut_port_arbiter owns the pointer register, FSM, timeout counter and response registers.

Test Plan:
- Single write: req 0 writes addr 5 data 1, both rdy=1 -> req_ready[0] at cycle 1; write_en with addr 5/data 1 at cycle 2; rsp_valid[0] with rsp_err=0 and rsp_data=0 at cycle 3.
- Read back: req 2 reads addr 5, dut read_data=1 -> read_en for exactly 1 cycle; rsp_valid[2] with rsp_data=1 the following cycle.
- Round-robin: all 4 requesters hold req_valid from reset -> grants in order 0,1,2,3,0; each req_ready is 3 cycles apart.
- Stall: write_rdy=0 for 5 cycles then 1 -> write_en stays 0 for 5 cycles, then one pulse; rsp_valid with rsp_err=0.
- Timeout: read_rdy held 0 with TIMEOUT=16 -> no read_en; rsp_valid with rsp_err=1 and rsp_data=0 after 16 ISSUE cycles; the next requester is then granted.
- Reset mid-ISSUE: RST for 1 cycle during a stall -> all outputs 0 next cycle; no rsp_valid for the dropped request; next grant goes to requester 0.
